// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared state encoding, opcodes and ALU codes for the multicycle controller
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    ADDR   = 4'd3,
    MEM_RD = 4'd4,
    MEM_WR = 4'd5,
    WB_ALU = 4'd6,
    WB_MEM = 4'd7,
    BR_U   = 4'd8,
    BR_C   = 4'd9,
    FAULT  = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Branch opcodes carry immediate bits in the low positions, matched with casez.
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_ORR    = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_PASS_B = 4'b0111;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;

  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - R-type opcode to ALU operation decoder
module aludec
  import arm_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [3:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_control = ALU_ADD;
      OP_SUB:  alu_control = ALU_SUB;
      OP_AND:  alu_control = ALU_AND;
      OP_ORR:  alu_control = ALU_ORR;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle ARM-subset control FSM with memory wait timeout
module mc_control_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        memRead,
  output logic        memWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        regWrite,
  output logic        memtoReg,
  output logic        reg2loc,
  output logic [1:0]  PCSrc,
  output logic [1:0]  AluSrcB,
  output logic [3:0]  AluControl,
  output logic        illegal,
  output logic        fault,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  wait_cnt;
  logic           timed_out;
  logic           set_illegal, set_fault, retire;
  logic [3:0]     alu_r;

  aludec u_aludec (
    .opcode      (instr),
    .alu_control (alu_r)
  );

  assign state     = state_q;
  // The current cycle is the TIMEOUT-th wait cycle; mem_ready still wins if present.
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_d == state_q && is_wait_state(state_q)) ? wait_cnt + CW'(1) : '0;
      if (retire)      instret <= instret + 32'd1;
      if (set_illegal) illegal <= 1'b1;
      if (set_fault)   fault   <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    imem_req    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    regWrite    = 1'b0;
    memtoReg    = 1'b0;
    reg2loc     = 1'b0;
    PCSrc       = PCSRC_PC4;
    AluSrcB     = SRCB_REG;
    AluControl  = 4'b0000;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = PCSRC_PC4;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d   = FAULT;
          set_fault = 1'b1;
        end
      end
      DECODE: begin
        casez (instr)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: state_d = EXEC_R;
          OP_LDUR, OP_STUR:               state_d = ADDR;
          OP_B:                           state_d = BR_U;
          OP_CBZ:                         state_d = BR_C;
          default: begin
            state_d     = FAULT;
            set_illegal = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        AluSrcB    = SRCB_REG;
        AluControl = alu_r;
        state_d    = WB_ALU;
      end
      WB_ALU: begin
        regWrite = 1'b1;
        state_d  = FETCH;
      end
      ADDR: begin
        AluSrcB    = SRCB_IMM;
        AluControl = ALU_ADD;
        state_d    = (instr == OP_LDUR) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        memRead = 1'b1;
        if (mem_ready) state_d = WB_MEM;
        else if (timed_out) begin
          state_d   = FAULT;
          set_fault = 1'b1;
        end
      end
      WB_MEM: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
        state_d  = FETCH;
      end
      MEM_WR: begin
        memWrite = 1'b1;
        reg2loc  = 1'b1;
        if (mem_ready) state_d = FETCH;
        else if (timed_out) begin
          state_d   = FAULT;
          set_fault = 1'b1;
        end
      end
      BR_U: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_BR;
        state_d = FETCH;
      end
      BR_C: begin
        reg2loc    = 1'b1;
        AluControl = ALU_PASS_B;
        PCSrc      = PCSRC_BR;
        PCWrite    = zero;
        state_d    = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    retire = (state_d == FETCH) &&
             (state_q == WB_ALU || state_q == WB_MEM || state_q == MEM_WR ||
              state_q == BR_U   || state_q == BR_C);

    // Outputs are held quiet while reset is low so a half-done instruction cannot commit.
    if (!reset_n) begin
      imem_req   = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      regWrite   = 1'b0;
      memtoReg   = 1'b0;
      reg2loc    = 1'b0;
      PCSrc      = 2'b00;
      AluSrcB    = 2'b00;
      AluControl = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed table-driven bench for mc_control_fsm
module tb_mc_control_fsm;
  import arm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        imem_req, memRead, memWrite, IRWrite, PCWrite, regWrite, memtoReg, reg2loc;
  logic [1:0]  PCSrc, AluSrcB;
  logic [3:0]  AluControl;
  logic        illegal, fault;
  logic [3:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  mc_control_fsm #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .imem_req   (imem_req),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .regWrite   (regWrite),
    .memtoReg   (memtoReg),
    .reg2loc    (reg2loc),
    .PCSrc      (PCSrc),
    .AluSrcB    (AluSrcB),
    .AluControl (AluControl),
    .illegal    (illegal),
    .fault      (fault),
    .state      (state),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] instr;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] outs;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  // {imem_req, memRead, memWrite, IRWrite, PCWrite, regWrite, memtoReg, reg2loc, PCSrc, AluSrcB, AluControl}
  function automatic logic [15:0] outs();
    return {imem_req, memRead, memWrite, IRWrite, PCWrite, regWrite, memtoReg, reg2loc,
            PCSrc, AluSrcB, AluControl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [10:0] i, input logic z, input logic mr, input logic [3:0] st,
                     input logic [15:0] o, input logic [31:0] ir);
    vecs.push_back('{i, z, mr, st, o, ir});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [10:0] op_b, op_cbz, op_bad;
    int cycles, nrd, wbm, waits, bad;
    logic [31:0] ir0;
    op_b   = 11'b00010100011;
    op_cbz = 11'b10110100101;
    op_bad = 11'b11111111111;

    add(OP_ADD,  0, 1, FETCH,  16'h9800, 0); add(OP_ADD,  0, 1, DECODE, 16'h0000, 0);
    add(OP_ADD,  0, 1, EXEC_R, 16'h0002, 0); add(OP_ADD,  0, 1, WB_ALU, 16'h0400, 0);
    add(OP_SUB,  0, 1, FETCH,  16'h9800, 1); add(OP_SUB,  0, 1, DECODE, 16'h0000, 1);
    add(OP_SUB,  0, 1, EXEC_R, 16'h0006, 1); add(OP_SUB,  0, 1, WB_ALU, 16'h0400, 1);
    add(OP_AND,  0, 1, FETCH,  16'h9800, 2); add(OP_AND,  0, 1, DECODE, 16'h0000, 2);
    add(OP_AND,  0, 1, EXEC_R, 16'h0000, 2); add(OP_AND,  0, 1, WB_ALU, 16'h0400, 2);
    add(OP_ORR,  0, 1, FETCH,  16'h9800, 3); add(OP_ORR,  0, 1, DECODE, 16'h0000, 3);
    add(OP_ORR,  0, 1, EXEC_R, 16'h0001, 3); add(OP_ORR,  0, 1, WB_ALU, 16'h0400, 3);
    add(OP_LDUR, 0, 1, FETCH,  16'h9800, 4); add(OP_LDUR, 0, 1, DECODE, 16'h0000, 4);
    add(OP_LDUR, 0, 1, ADDR,   16'h0012, 4); add(OP_LDUR, 0, 1, MEM_RD, 16'h4000, 4);
    add(OP_LDUR, 0, 1, WB_MEM, 16'h0600, 4);
    add(OP_STUR, 0, 1, FETCH,  16'h9800, 5); add(OP_STUR, 0, 1, DECODE, 16'h0000, 5);
    add(OP_STUR, 0, 1, ADDR,   16'h0012, 5); add(OP_STUR, 0, 1, MEM_WR, 16'h2100, 5);
    add(op_b,    0, 1, FETCH,  16'h9800, 6); add(op_b,    0, 1, DECODE, 16'h0000, 6);
    add(op_b,    0, 1, BR_U,   16'h0840, 6);
    add(op_cbz,  1, 1, FETCH,  16'h9800, 7); add(op_cbz,  1, 1, DECODE, 16'h0000, 7);
    add(op_cbz,  1, 1, BR_C,   16'h0947, 7);
    add(op_cbz,  0, 1, FETCH,  16'h9800, 8); add(op_cbz,  0, 1, DECODE, 16'h0000, 8);
    add(op_cbz,  0, 1, BR_C,   16'h0147, 8);
    add(OP_ADD,  0, 0, FETCH,  16'h8000, 9);

    // Reset state with mem_ready high: everything quiet.
    mem_ready = 1'b1;
    step();
    chk("reset_state",   state,   FETCH);
    chk("reset_outs",    outs(),  16'h0000);
    chk("reset_instret", instret, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_fault",   fault,   0);

    reset_n   = 1'b1;
    mem_ready = 1'b0;
    step();
    chk("post_reset_state", state, FETCH);
    chk("post_reset_imem",  imem_req, 1);

    foreach (vecs[k]) begin
      instr     = vecs[k].instr;
      zero      = vecs[k].zero;
      mem_ready = vecs[k].mr;
      #1;
      chk($sformatf("vec%0d_state", k),   state,   vecs[k].st);
      chk($sformatf("vec%0d_outs", k),    outs(),  vecs[k].outs);
      chk($sformatf("vec%0d_instret", k), instret, vecs[k].ir);
      step();
    end

    // LDUR with three wait cycles in MEM_RD.
    instr = OP_LDUR; zero = 0; ir0 = instret;
    cycles = 0; nrd = 0; wbm = 0; waits = 0;
    for (int c = 0; c < 20; c++) begin
      if (state == MEM_RD && waits < 3) begin
        mem_ready = 1'b0;
        waits++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (memRead) nrd++;
      if (state == WB_MEM && memtoReg) wbm++;
      cycles++;
      step();
      if (state == FETCH) break;
    end
    chk("ldur_wait_cycles",  cycles, 8);
    chk("ldur_wait_memread", nrd, 4);
    chk("ldur_wait_wbmem",   wbm, 1);
    chk("ldur_wait_instret", instret, ir0 + 1);

    // Reset landing in MEM_WR.
    do_reset();
    instr = OP_STUR; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    chk("stur_in_memwr",  state, MEM_WR);
    chk("stur_memwrite",  memWrite, 1);
    reset_n = 1'b0;
    #1;
    chk("stur_rst_memwrite", memWrite, 0);
    chk("stur_rst_state",    state, FETCH);
    chk("stur_rst_outs",     outs(), 16'h0000);
    step();
    reset_n = 1'b1;
    step();
    chk("stur_rst_instret",  instret, 0);

    // Illegal opcode: absorbing FAULT.
    do_reset();
    instr = op_bad; mem_ready = 1'b1;
    step();
    step();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      #1;
      if (state != FAULT || illegal !== 1'b1 || fault !== 1'b0 || outs() !== 16'h0000) bad++;
      step();
    end
    chk("illegal_hold_bad", bad, 0);
    chk("illegal_flag",     illegal, 1);
    chk("illegal_instret",  instret, 0);

    // FETCH timeout after 16 wait cycles.
    do_reset();
    instr = OP_ADD;
    for (int c = 0; c < 15; c++) step();
    chk("to15_state", state, FETCH);
    chk("to15_fault", fault, 0);
    step();
    chk("to16_state",   state, FAULT);
    chk("to16_fault",   fault, 1);
    chk("to16_illegal", illegal, 0);
    chk("to16_outs",    outs(), 16'h0000);

    // mem_ready on the 16th wait cycle beats the timeout.
    do_reset();
    for (int c = 0; c < 15; c++) step();
    mem_ready = 1'b1;
    #1;
    chk("late_ready_irwrite", IRWrite, 1);
    step();
    chk("late_ready_state", state, DECODE);
    chk("late_ready_fault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
